// File: rtl/if_id_buffer.sv
// IF->ID pipeline register: 2-entry skid buffer with valid/ready handshake,
// flush for wrong-path fetches and a saturating bubble counter.
module if_id_buffer #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [XLEN-1:0]  out_pc_plus4,
    output logic [31:0]      out_instr,
    output logic [CNT_W-1:0] bubble_count
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           r_state;
    state_e           w_state_d;
    logic [XLEN-1:0]  r_main_pc;
    logic [31:0]      r_main_instr;
    logic [XLEN-1:0]  r_skid_pc;
    logic [31:0]      r_skid_instr;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Handshake status depends on the state register only, so a decode
    // stall never reaches fetch combinationally.
    always_comb begin
        in_ready   = (r_state != StTwo);
        out_valid  = (r_state != StEmpty);
        w_in_fire  = in_valid & in_ready;
        w_out_fire = out_valid & out_ready;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state and storage-load decode; flush overrides every handshake.
    always_comb begin
        w_state_d        = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_d = StEmpty;
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_fire) begin
                        w_state_d      = StOne;
                        w_load_main_in = 1'b1;
                    end
                end
                StOne: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main_in = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_d   = StTwo;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (w_out_fire) begin
                        w_state_d        = StOne;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_d = StEmpty;
            endcase
        end
    end

    // Main and skid entry storage.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main_pc    <= '0;
            r_main_instr <= NOP_INSTR;
            r_skid_pc    <= '0;
            r_skid_instr <= NOP_INSTR;
        end else begin
            if (w_load_main_in) begin
                r_main_pc    <= in_pc;
                r_main_instr <= in_instr;
            end else if (w_load_main_skid) begin
                r_main_pc    <= r_skid_pc;
                r_main_instr <= r_skid_instr;
            end
            if (w_load_skid) begin
                r_skid_pc    <= in_pc;
                r_skid_instr <= in_instr;
            end
        end
    end

    // Saturating count of cycles where decode was ready but starved.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !out_valid && !flush && (r_bubble_cnt != CntMax)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    // Output presentation; an empty buffer shows a NOP at PC 0.
    always_comb begin
        out_pc       = out_valid ? r_main_pc : '0;
        out_instr    = out_valid ? r_main_instr : NOP_INSTR;
        out_pc_plus4 = out_pc + XLEN'(4);
        bubble_count = r_bubble_cnt;
    end

endmodule
